// File: rtl/mips_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over a req/valid handshake and
// holds each word for decode; branch/jump redirects flush in-flight fetches.
module mips_fetch_unit #(
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned           COUNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic                   imem_valid,
    input  logic [DATA_WIDTH-1:0]  imem_rdata,
    output logic                   instr_valid,
    output logic [DATA_WIDTH-1:0]  instr,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    input  logic                   instr_ready,
    input  logic                   br_taken,
    input  logic                   jump,
    input  logic [ADDR_WIDTH-1:0]  redir_pc,
    input  logic [15:0]            br_offset,
    input  logic [25:0]            jmp_index,
    output logic [COUNT_WIDTH-1:0] fetch_count
);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_OUT, S_DROP} state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] pc, pc_next;
    logic [ADDR_WIDTH-1:0] seq_pc, br_disp, br_target, jmp_target, target;
    logic                  redirect, load, deliver;

    // Redirect target; branch wins when both redirect sources are high
    assign seq_pc    = redir_pc + ADDR_WIDTH'(4);
    assign br_disp   = {{(ADDR_WIDTH-18){br_offset[15]}}, br_offset, 2'b00};
    assign br_target = seq_pc + br_disp;

    generate
        if (ADDR_WIDTH > 28) begin : g_jmp_hi
            assign jmp_target = {seq_pc[ADDR_WIDTH-1:28], jmp_index, 2'b00};
        end else begin : g_jmp_lo
            assign jmp_target = {jmp_index, 2'b00};
        end
    endgenerate

    assign redirect = br_taken | jump;
    assign target   = br_taken ? br_target : jmp_target;

    assign imem_req    = (state == S_FETCH) && !reset;
    assign imem_addr   = pc;
    assign instr_valid = (state == S_OUT);
    assign deliver     = instr_valid && instr_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
            pc    <= RESET_VECTOR;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        load       = 1'b0;
        unique case (state)
            S_FETCH: begin
                if (redirect) begin
                    pc_next    = target;
                    state_next = S_DROP;
                end else begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_next    = target;
                    state_next = imem_valid ? S_FETCH : S_DROP;
                end else if (imem_valid) begin
                    load       = 1'b1;
                    pc_next    = pc + ADDR_WIDTH'(4);
                    state_next = S_OUT;
                end
            end
            S_OUT: begin
                if (redirect) begin
                    pc_next    = target;
                    state_next = S_FETCH;
                end else if (instr_ready) begin
                    state_next = S_FETCH;
                end
            end
            S_DROP: begin
                if (redirect) pc_next = target;
                if (imem_valid) state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // Held instruction and saturating delivery counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr       <= '0;
            instr_pc    <= '0;
            fetch_count <= '0;
        end else begin
            if (load) begin
                instr    <= imem_rdata;
                instr_pc <= pc;
            end
            if (deliver && (fetch_count != {COUNT_WIDTH{1'b1}}))
                fetch_count <= fetch_count + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Self-checking bench for mips_fetch_unit: stream-level model of delivered
// instructions plus directed literal checks; a second DUT has a 2-bit counter.
`timescale 1ns/1ps
module tb_mips_fetch_unit;

    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_ready = 1'b1;
    logic        br_taken = 1'b0, jump = 1'b0;
    logic [31:0] redir_pc = '0;
    logic [15:0] br_offset = '0;
    logic [25:0] jmp_index = '0;

    logic        imem_req, instr_valid, imem_req2, instr_valid2;
    logic [31:0] imem_addr, instr, instr_pc, imem_addr2, instr2, instr_pc2;
    logic [15:0] fetch_count;
    logic [1:0]  fetch_count2;

    int n_checks = 0, n_fail = 0;
    int lat = 1;
    logic late_valid = 1'b0;

    always #5 clk = ~clk;

    mips_fetch_unit dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
        .br_taken(br_taken), .jump(jump), .redir_pc(redir_pc), .br_offset(br_offset),
        .jmp_index(jmp_index), .fetch_count(fetch_count));

    mips_fetch_unit #(.COUNT_WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata), .instr_valid(instr_valid2),
        .instr(instr2), .instr_pc(instr_pc2), .instr_ready(instr_ready),
        .br_taken(br_taken), .jump(jump), .redir_pc(redir_pc), .br_offset(br_offset),
        .jmp_index(jmp_index), .fetch_count(fetch_count2));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] br_tgt(input logic [31:0] rpc, input logic [15:0] off);
        int signed o;
        o = int'($signed(off));
        return rpc + 32'd4 + 32'(o * 4);
    endfunction

    function automatic logic [31:0] jmp_tgt(input logic [31:0] rpc, input logic [25:0] idx);
        return ((rpc + 32'd4) & 32'hF000_0000) | (32'(idx) << 2);
    endfunction

    // Memory: request seen in cycle c answers in cycle c+lat with addr^KEY
    logic        pend = 1'b0;
    int          dly = 0;
    logic [31:0] maddr = '0;
    always begin
        @(negedge clk);
        if (imem_req) begin pend = 1'b1; dly = lat; maddr = imem_addr; end
        @(posedge clk);
        #2;
        imem_valid = late_valid;
        if (pend) begin
            dly--;
            if (dly == 0) begin
                imem_valid = 1'b1;
                imem_rdata = maddr ^ KEY;
                pend = 1'b0;
            end
        end
    end

    // Stream model: next delivered PC, number of deliveries, hold tracking
    logic [31:0] exp_pc = '0;
    int          raw = 0, cyc_n = 0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_instr = '0, prev_pc = '0;
    logic [31:0] tq[$];
    int          tcyc[$];

    always @(negedge clk) begin
        if (reset) begin
            exp_pc = '0; raw = 0; prev_hold = 1'b0;
            check("rst_req", 64'(imem_req), 64'd0);
            check("rst_req2", 64'(imem_req2), 64'd0);
            check("rst_valid", 64'(instr_valid), 64'd0);
            check("rst_addr2", 64'(imem_addr2), 64'd0);
        end else begin
            cyc_n++;
            check("count", 64'(fetch_count), 64'(raw));
            check("count2_sat", 64'(fetch_count2), 64'(raw > 3 ? 3 : raw));
            if (!late_valid) begin
                check("one_outstanding", 64'(imem_req && imem_valid), 64'd0);
                check("one_outstanding2", 64'(imem_req2 && imem_valid), 64'd0);
            end
            if (prev_hold && instr_valid) begin
                check("hold_instr", 64'(instr), 64'(prev_instr));
                check("hold_pc", 64'(instr_pc), 64'(prev_pc));
            end
            if (instr_valid2 && instr_ready) begin
                check("dut2_pc", 64'(instr_pc2), 64'(exp_pc));
                check("dut2_instr", 64'(instr2), 64'(exp_pc ^ KEY));
            end
            if (instr_valid && instr_ready) begin
                check("model_pc", 64'(instr_pc), 64'(exp_pc));
                check("model_instr", 64'(instr), 64'(exp_pc ^ KEY));
                tq.push_back(instr_pc);
                tcyc.push_back(cyc_n);
                exp_pc = exp_pc + 32'd4;
                raw++;
            end
            prev_hold  = instr_valid && !instr_ready && !(br_taken || jump);
            prev_instr = instr;
            prev_pc    = instr_pc;
            if (br_taken)  exp_pc = br_tgt(redir_pc, br_offset);
            else if (jump) exp_pc = jmp_tgt(redir_pc, jmp_index);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_req", 64'(imem_req), 64'd0);
        check("reset_instr_valid", 64'(instr_valid), 64'd0);
        check("reset_count", 64'(fetch_count), 64'd0);
        check("reset_instr", 64'(instr), 64'd0);
        check("reset_instr_pc", 64'(instr_pc), 64'd0);

        // Free-running fetch with a 1-cycle memory
        step(); reset = 1'b0;
        @(negedge clk);
        check("first_req", 64'(imem_req), 64'd1);
        check("first_addr", 64'(imem_addr), 64'd0);
        repeat (12) @(posedge clk);
        #1;
        @(negedge clk);
        check("count_after_12", 64'(fetch_count), 64'd4);
        check("n_transfers", 64'(tq.size()), 64'd4);
        if (tq.size() == 4) begin
            for (int i = 0; i < 4; i++) check("seq_pc", 64'(tq[i]), 64'(4 * i));
            for (int i = 0; i < 3; i++) check("every_3rd", 64'(tcyc[i+1] - tcyc[i]), 64'd3);
        end

        // Backpressure
        step(); instr_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!instr_valid && n < 10) begin @(negedge clk); n++; end
        check("bp_reached_out", 64'(instr_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            check("bp_no_req", 64'(imem_req), 64'd0);
            check("bp_instr_pc", 64'(instr_pc), 64'h10);
            check("bp_instr", 64'(instr), 64'(32'h10 ^ KEY));
            if (i < 4) @(negedge clk);
        end
        step(); instr_ready = 1'b1;
        @(negedge clk);
        check("bp_count_before", 64'(fetch_count), 64'd4);
        step();
        @(negedge clk);
        check("bp_count_after", 64'(fetch_count), 64'd5);
        check("bp_valid_gone", 64'(instr_valid), 64'd0);
        check("bp_next_addr", 64'(imem_addr), 64'h14);

        // Branch while waiting: target 0x10+4-8 = 0x0C
        step(); br_taken = 1'b1; redir_pc = 32'h10; br_offset = 16'hFFFE;
        @(negedge clk);
        check("br_wait_valid", 64'(instr_valid), 64'd0);
        step(); br_taken = 1'b0;
        @(negedge clk);
        check("br_req", 64'(imem_req), 64'd1);
        check("br_addr", 64'(imem_addr), 64'h0C);
        check("br_dropped", 64'(fetch_count), 64'd5);
        step(); step();
        @(negedge clk);
        check("br_deliver_pc", 64'(instr_pc), 64'h0C);

        // Jump while OUT with instr_ready high
        repeat (3) step();
        jump = 1'b1; redir_pc = 32'hF000_0000; jmp_index = 26'h40;
        @(negedge clk);
        check("jmp_out_pc", 64'(instr_pc), 64'h10);
        check("jmp_count_pre", 64'(fetch_count), 64'd6);
        step(); jump = 1'b0;
        @(negedge clk);
        check("jmp_counted", 64'(fetch_count), 64'd7);
        check("jmp_addr", 64'(imem_addr), 64'hF000_0100);

        // Branch+jump together in FETCH, then an overriding branch in DROP
        repeat (3) step();
        lat = 3;
        br_taken = 1'b1; jump = 1'b1; redir_pc = 32'h100; br_offset = 16'h0003; jmp_index = 26'h3FF_FFFF;
        @(negedge clk);
        check("bj_req_addr", 64'(imem_addr), 64'hF000_0104);
        step(); jump = 1'b0; redir_pc = 32'h200; br_offset = 16'h0000;
        @(negedge clk);
        check("drop_no_req", 64'(imem_req), 64'd0);
        step(); br_taken = 1'b0;
        @(negedge clk);
        check("drop_stays", 64'(imem_req), 64'd0);
        step(); lat = 1;
        @(negedge clk);
        check("drop_resp", 64'(imem_req), 64'd0);
        step();
        @(negedge clk);
        check("drop_override_addr", 64'(imem_addr), 64'h204);
        repeat (2) step();
        @(negedge clk);
        check("drop_deliver_pc", 64'(instr_pc), 64'h204);

        // Reset asserted in WAIT, late response after release
        repeat (2) step();
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_req", 64'(imem_req), 64'd0);
        check("mid_rst_valid", 64'(instr_valid), 64'd0);
        check("mid_rst_pc", 64'(imem_addr), 64'd0);
        check("mid_rst_count", 64'(fetch_count), 64'd0);
        step(); reset = 1'b0; late_valid = 1'b1;
        @(negedge clk);
        check("post_rst_addr", 64'(imem_addr), 64'd0);
        step(); late_valid = 1'b0;
        step();
        @(negedge clk);
        check("post_rst_pc", 64'(instr_pc), 64'd0);
        check("post_rst_instr", 64'(instr), 64'(KEY));

        // Run to five deliveries since reset to exercise 2-bit saturation
        n = 1;
        for (int i = 0; i < 40 && n < 5; i++) begin
            @(negedge clk);
            if (instr_valid && instr_ready) n++;
        end
        check("five_deliveries", 64'(n), 64'd5);
        step();
        @(negedge clk);
        check("count_five", 64'(fetch_count), 64'd5);
        check("count2_sat_3", 64'(fetch_count2), 64'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
